// File: rtl/calc_alu_sequencer.sv
// Fixed-point (0.01 units) calculator ALU: single-cycle add/sub plus shared
// iterative shift-add multiplier and restoring divider, with +/-9999 saturation.
module calc_alu_sequencer (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    input  logic               clear,
    output logic               busy,
    output logic               done,
    output logic signed [15:0] result,
    output logic               ovf,
    output logic               dz
);

    localparam int          DATA_W  = 16;
    localparam logic [1:0]  OP_ADD  = 2'b00;
    localparam logic [1:0]  OP_SUB  = 2'b01;
    localparam logic [1:0]  OP_MUL  = 2'b10;
    localparam logic [1:0]  OP_DIV  = 2'b11;
    localparam logic [DATA_W-1:0] SCALE   = 16'd100;
    localparam logic [31:0]       MAX_MAG = 32'd9999;

    typedef enum logic [2:0] {IDLE, ADDSUB, MULP, DIVP, NORM, DONE} state_t;

    state_t state, state_nxt;
    logic [4:0] cnt;
    logic       accept;

    logic [1:0]               op_q;
    logic signed [DATA_W-1:0] a_q, b_q;
    logic [31:0]              acc;
    logic [31:0]              mcand;
    logic [DATA_W-1:0]        mplier;
    logic [DATA_W-1:0]        divisor;
    logic [DATA_W-1:0]        rem;
    logic                     neg;
    logic                     div0;

    logic signed [DATA_W:0] sum_ext;
    logic [DATA_W:0]        sum_mag;
    logic [DATA_W:0]        rem_sh;
    logic [DATA_W:0]        rem_diff;
    logic [DATA_W:0]        norm_out;

    function automatic logic [DATA_W-1:0] abs16(input logic signed [DATA_W-1:0] v);
        // -32768 maps to 0x8000, which reads correctly as unsigned 32768
        return v[DATA_W-1] ? DATA_W'(-v) : DATA_W'(v);
    endfunction

    // Returns {ovf, signed result}; a zero magnitude stays +0 regardless of neg.
    function automatic logic [DATA_W:0] sat_norm(input logic [31:0] mag, input logic sgn);
        logic              ov;
        logic [DATA_W-1:0] m;
        ov = (mag > MAX_MAG);
        m  = ov ? MAX_MAG[DATA_W-1:0] : mag[DATA_W-1:0];
        if (sgn) m = DATA_W'(0) - m;
        return {ov, m};
    endfunction

    assign accept = (state == IDLE) && start && !clear;
    assign busy   = (state == ADDSUB) || (state == MULP) || (state == DIVP) || (state == NORM);
    assign done   = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (start) begin
                    if (op == OP_ADD || op == OP_SUB)  state_nxt = ADDSUB;
                    else if (op == OP_DIV && b == '0)  state_nxt = NORM;
                    else                               state_nxt = MULP;
                end
                ADDSUB: state_nxt = NORM;
                MULP:   if (cnt == 5'd15) state_nxt = DIVP;
                DIVP:   if (cnt == 5'd31) state_nxt = NORM;
                NORM:   state_nxt = DONE;
                DONE:   state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Iteration counter restarts on every state change, so MULP/DIVP each begin at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (state_nxt == state && (state == MULP || state == DIVP))
            cnt <= cnt + 5'd1;
        else
            cnt <= '0;
    end

    always_comb begin
        if (op_q == OP_SUB) sum_ext = {a_q[DATA_W-1], a_q} - {b_q[DATA_W-1], b_q};
        else                sum_ext = {a_q[DATA_W-1], a_q} + {b_q[DATA_W-1], b_q};
        sum_mag  = sum_ext[DATA_W] ? (DATA_W+1)'(-sum_ext) : sum_ext;
        rem_sh   = {rem, acc[31]};
        rem_diff = rem_sh - {1'b0, divisor};
        norm_out = sat_norm(acc, neg);
    end

    // Datapath: acc holds the product during MULP and becomes the quotient in DIVP.
    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (accept) begin
                op_q    <= op;
                a_q     <= a;
                b_q     <= b;
                mcand   <= {16'd0, abs16(a)};
                mplier  <= (op == OP_DIV) ? SCALE : abs16(b);
                divisor <= (op == OP_DIV) ? abs16(b) : SCALE;
                acc     <= '0;
                rem     <= '0;
                neg     <= a[DATA_W-1] ^ b[DATA_W-1];
                div0    <= (op == OP_DIV) && (b == '0);
            end
            ADDSUB: begin
                acc <= {15'd0, sum_mag};
                neg <= sum_ext[DATA_W];
            end
            MULP: begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
            DIVP: begin
                if (rem_sh >= {1'b0, divisor}) begin
                    rem <= rem_diff[DATA_W-1:0];
                    acc <= {acc[30:0], 1'b1};
                end else begin
                    rem <= rem_sh[DATA_W-1:0];
                    acc <= {acc[30:0], 1'b0};
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result <= '0;
            ovf    <= 1'b0;
            dz     <= 1'b0;
        end else if (clear) begin
            result <= '0;
            ovf    <= 1'b0;
            dz     <= 1'b0;
        end else if (state == NORM) begin
            if (div0) begin
                result <= '0;
                ovf    <= 1'b0;
                dz     <= 1'b1;
            end else begin
                {ovf, result} <= norm_out;
                dz            <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_calc_alu_sequencer.sv
// Self-checking bench: latency/value model from plain integer arithmetic,
// compared every cycle, plus directed literal cases.
module tb_calc_alu_sequencer;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [1:0]         op;
    logic signed [15:0] a, b;
    logic               clear;
    logic               busy, done, ovf, dz;
    logic signed [15:0] result;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    calc_alu_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .clear(clear), .busy(busy), .done(done), .result(result),
        .ovf(ovf), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic signed [15:0] res;
        logic               ovf;
        logic               dz;
    } exp_t;

    function automatic exp_t model_op(logic [1:0] o, logic signed [15:0] x, logic signed [15:0] y);
        exp_t   e;
        longint xi, yi, ax, ay, v;
        xi = x; yi = y;
        ax = (xi < 0) ? -xi : xi;
        ay = (yi < 0) ? -yi : yi;
        e.dz = 1'b0; e.ovf = 1'b0;
        case (o)
            2'd0: v = xi + yi;
            2'd1: v = xi - yi;
            2'd2: begin
                v = (ax * ay) / 100;
                if ((xi < 0) != (yi < 0)) v = -v;
            end
            default: begin
                if (yi == 0) begin
                    v = 0; e.dz = 1'b1;
                end else begin
                    v = (ax * 100) / ay;
                    if ((xi < 0) != (yi < 0)) v = -v;
                end
            end
        endcase
        if (v > 9999)  begin v = 9999;  e.ovf = 1'b1; end
        if (v < -9999) begin v = -9999; e.ovf = 1'b1; end
        e.res = 16'(v);
        return e;
    endfunction

    function automatic int op_latency(logic [1:0] o, logic signed [15:0] y);
        if (o == 2'd0 || o == 2'd1) return 3;
        if (o == 2'd3 && y == 0)    return 2;
        return 50;
    endfunction

    // Reference: an accepted operation completes op_latency edges after edge 0.
    int                 m_cnt  = 0;
    logic               m_busy = 1'b0;
    logic               m_done = 1'b0;
    logic signed [15:0] m_res  = '0;
    logic               m_ovf  = 1'b0;
    logic               m_dz   = 1'b0;
    exp_t               pend   = '0;

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            m_cnt <= 0; m_busy <= 1'b0; m_done <= 1'b0;
            m_res <= '0; m_ovf <= 1'b0; m_dz <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0; m_done <= 1'b1;
                    m_res <= pend.res; m_ovf <= pend.ovf; m_dz <= pend.dz;
                end
            end else if (start && !m_done) begin
                pend   <= model_op(op, a, b);
                m_cnt  <= op_latency(op, b) - 1;
                m_busy <= 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc busy",   int'(busy),   int'(m_busy));
            chk("cyc done",   int'(done),   int'(m_done));
            chk("cyc result", int'(result), int'(m_res));
            chk("cyc ovf",    int'(ovf),    int'(m_ovf));
            chk("cyc dz",     int'(dz),     int'(m_dz));
        end
    end

    task automatic run_lit(input string nm, input logic [1:0] o, input int av, input int bv,
                           input int er, input int eo, input int ed, input int el,
                           input int pulse_at);
        int lat; bit got;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = 16'(av); b = 16'(bv);
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (done) got = 1'b1;
            else if (pulse_at != 0 && lat == pulse_at) begin
                start = 1'b1; op = 2'd0; a = 16'sd1; b = 16'sd1;
            end else start = 1'b0;
        end
        start = 1'b0;
        chk({nm, " done_seen"}, int'(got), 1);
        chk({nm, " latency"},   lat, el);
        chk({nm, " result"},    int'(result), er);
        chk({nm, " ovf"},       int'(ovf), eo);
        chk({nm, " dz"},        int'(dz), ed);
    endtask

    task automatic no_done_for(input string nm, input int n);
        int cnt_d = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) cnt_d++;
        end
        chk(nm, cnt_d, 0);
    endtask

    function automatic logic signed [15:0] rand_operand();
        int v;
        case ($urandom % 4)
            0: v = int'($urandom_range(0, 600)) - 300;
            1: v = int'($urandom_range(0, 65535)) - 32768;
            2: v = int'($urandom_range(0, 19998)) - 9999;
            default: v = int'($urandom_range(0, 2)) - 1;
        endcase
        return 16'(v);
    endfunction

    task automatic run_rand();
        int n; bit got;
        logic [1:0] o;
        logic signed [15:0] x, y;
        o = 2'($urandom % 4);
        x = rand_operand();
        y = rand_operand();
        if (o == 2'd3 && ($urandom % 5) == 0) y = '0;
        @(posedge clk); #1;
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (done) got = 1'b1;
            else if (($urandom % 10) == 0) begin
                start = 1'b1; op = 2'($urandom % 4); a = rand_operand(); b = rand_operand();
            end else start = 1'b0;
        end
        start = 1'b0;
        chk("rand done_seen", int'(got), 1);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1 chk_en = 1'b1;
        chk("reset busy",   int'(busy), 0);
        chk("reset done",   int'(done), 0);
        chk("reset result", int'(result), 0);
        chk("reset ovf",    int'(ovf), 0);
        chk("reset dz",     int'(dz), 0);

        run_lit("sub",       2'd1,   525,  725,  -200, 0, 0, 3, 0);
        run_lit("div",       2'd3,  -200,  200,  -100, 0, 0, 50, 0);
        run_lit("mul chain", 2'd2,  -100,  800,  -800, 0, 0, 50, 0);
        run_lit("mul",       2'd2,   200,  800,  1600, 0, 0, 50, 0);
        run_lit("add sat",   2'd0,  9999,    1,  9999, 1, 0, 3, 0);
        run_lit("mul sat",   2'd2, -5000,  500, -9999, 1, 0, 50, 0);
        run_lit("sub sat",   2'd1, -9999, 9999, -9999, 1, 0, 3, 0);
        run_lit("mul zero",  2'd2,     0, -500,     0, 0, 0, 50, 0);
        run_lit("div0",      2'd3,   500,    0,     0, 0, 1, 2, 0);
        run_lit("add after", 2'd0,     1,    1,     2, 0, 0, 3, 0);

        // clear at edge0+10 of a MUL, with ovf set beforehand
        run_lit("pre clear", 2'd0,  9999,    5,  9999, 1, 0, 3, 0);
        @(posedge clk); #1;
        start = 1'b1; op = 2'd2; a = 16'sd300; b = 16'sd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear busy",   int'(busy), 0);
        chk("clear result", int'(result), 0);
        chk("clear ovf",    int'(ovf), 0);
        no_done_for("clear no_done", 60);

        run_lit("busy start", 2'd2, 200, 800, 1600, 0, 0, 50, 5);

        // rst during DIVP
        run_lit("pre rst", 2'd0, 1, 1, 2, 0, 0, 3, 0);
        @(posedge clk); #1;
        start = 1'b1; op = 2'd3; a = 16'sd700; b = 16'sd300;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("rst busy",   int'(busy), 0);
        chk("rst result", int'(result), 0);
        @(posedge clk); #2 rst = 1'b0;
        no_done_for("rst no_done", 60);
        run_lit("post rst", 2'd0, 3, 4, 7, 0, 0, 3, 0);

        // start and clear together in IDLE
        @(posedge clk); #1;
        start = 1'b1; clear = 1'b1; op = 2'd0; a = 16'sd10; b = 16'sd20;
        @(posedge clk); #1;
        start = 1'b0; clear = 1'b0;
        @(negedge clk);
        chk("start+clear busy",   int'(busy), 0);
        chk("start+clear result", int'(result), 0);
        no_done_for("start+clear no_done", 10);

        for (int i = 0; i < 40; i++) run_rand();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
